// File: rtl/adrv9001_spi_pkg.sv
// Shared definitions for the ADRV9001 SPI master: FSM states, TX entry layout
// and SPI mode constants.
package adrv9001_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DESEL = 3'd5
  } spi_state_t;

  // TX FIFO entry: {enable, data}; enable=1 keeps CSn low after this byte
  localparam int unsigned TX_W        = 9;
  localparam int unsigned RX_W        = 8;
  localparam int unsigned TX_EN_BIT   = 8;
  localparam int unsigned TX_DATA_MSB = 7;
  localparam int unsigned TX_DATA_LSB = 0;

  // Mode 0: SCLK idles low, data sampled on the rising edge
  localparam logic SPI_CPOL   = 1'b0;
  localparam logic CSN_IDLE   = 1'b1;
  localparam logic CSN_ACTIVE = 1'b0;

  function automatic logic [TX_W-1:0] tx_entry(input logic en, input logic [7:0] data);
    return {en, data};
  endfunction

endpackage

// File: rtl/adrv9001_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module adrv9001_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL_M1 = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] COUNT_ONE     = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  // Flags are registered, so a push on a full FIFO is refused even if a pop
  // frees a slot in the same cycle.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10: begin
          count <= count + COUNT_ONE;
          full  <= (count == COUNT_FULL_M1);
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - COUNT_ONE;
          full  <= 1'b0;
          empty <= (count == COUNT_ONE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/adrv9001_spi_master.sv
// SPI mode-0 master for the ADRV9001 control port: buffered TX bytes are
// shifted out MSB first, and every received byte is returned through an RX FIFO.
module adrv9001_spi_master
  import adrv9001_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned CS_IDLE    = 4
) (
  input  logic       s_axi_aclk,
  input  logic       s_axi_areset,
  input  logic [7:0] mspi_axis_tdata,
  input  logic       mspi_axis_tvalid,
  input  logic       mspi_axis_enable,
  output logic       mspi_axis_tready,
  output logic [7:0] sspi_axis_tdata,
  output logic       sspi_axis_tvalid,
  input  logic       sspi_axis_tready,
  output logic       spi_clk,
  output logic       spi_csn,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       busy,
  output logic       tx_overflow,
  output logic       rx_overflow
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE - 1);
  localparam logic [CW-1:0] RISE_AT    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FALL_AT    = CW'(2 * CLK_DIV - 1);

  spi_state_t       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic             hold_cs;
  logic             rx_push;
  logic [7:0]       rx_byte;

  logic [TX_W-1:0]  tx_head;
  logic             tx_full;
  logic             tx_empty;
  logic             tx_pop;
  logic             rx_full;
  logic             rx_empty;

  assign mspi_axis_tready = !tx_full;
  assign sspi_axis_tvalid = !rx_empty;

  adrv9001_sync_fifo #(
    .WIDTH (TX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (s_axi_aclk),
    .rst     (s_axi_areset),
    .wr_data (tx_entry(mspi_axis_enable, mspi_axis_tdata)),
    .wr_en   (mspi_axis_tvalid),
    .full    (tx_full),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty)
  );

  adrv9001_sync_fifo #(
    .WIDTH (RX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (s_axi_aclk),
    .rst     (s_axi_areset),
    .wr_data (rx_byte),
    .wr_en   (rx_push),
    .full    (rx_full),
    .rd_en   (sspi_axis_tready),
    .rd_data (sspi_axis_tdata),
    .empty   (rx_empty)
  );

  // GAP must keep SCLK low for at least one half-period before the next byte
  always_comb begin
    tx_pop = 1'b0;
    case (state)
      ST_IDLE: tx_pop = !tx_empty;
      ST_GAP:  tx_pop = !tx_empty && (cnt >= RISE_AT);
      default: tx_pop = 1'b0;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      hold_cs  <= 1'b0;
      rx_push  <= 1'b0;
      rx_byte  <= '0;
      spi_clk  <= SPI_CPOL;
      spi_csn  <= CSN_IDLE;
      spi_mosi <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_sr    <= tx_head[TX_DATA_MSB:TX_DATA_LSB];
            hold_cs  <= tx_head[TX_EN_BIT];
            spi_mosi <= tx_head[TX_DATA_MSB];
            spi_csn  <= CSN_ACTIVE;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_SHIFT: begin
          if (cnt == RISE_AT) begin
            spi_clk <= ~SPI_CPOL;
            rx_sr   <= {rx_sr[6:0], spi_miso};
            cnt     <= cnt + CW'(1);
          end else if (cnt == FALL_AT) begin
            spi_clk  <= SPI_CPOL;
            cnt      <= '0;
            tx_sr    <= {tx_sr[6:0], 1'b0};
            spi_mosi <= tx_sr[6];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_push <= 1'b1;
              rx_byte <= rx_sr;
              state   <= hold_cs ? ST_GAP : ST_HOLD;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_GAP: begin
          if (tx_pop) begin
            tx_sr    <= tx_head[TX_DATA_MSB:TX_DATA_LSB];
            hold_cs  <= tx_head[TX_EN_BIT];
            spi_mosi <= tx_head[TX_DATA_MSB];
            bit_cnt  <= '0;
            cnt      <= '0;
            state    <= ST_SHIFT;
          end else if (cnt < RISE_AT) begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            spi_csn <= CSN_IDLE;
            cnt     <= '0;
            state   <= ST_DESEL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_DESEL: begin
          if (cnt == IDLE_LAST) begin
            busy  <= 1'b0;
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      tx_overflow <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      if (mspi_axis_tvalid && tx_full) tx_overflow <= 1'b1;
      if (rx_push && rx_full)          rx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adrv9001_spi_master.sv
// Self-checking bench for adrv9001_spi_master with MISO looped back to MOSI.
module tb_adrv9001_spi_master;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned CS_IDLE  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] m_tdata = '0;
  logic       m_tvalid = 1'b0;
  logic       m_enable = 1'b0;
  logic       m_tready;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready = 1'b0;
  logic       spi_clk, spi_csn, spi_mosi, spi_miso;
  logic       busy, tx_overflow, rx_overflow;

  assign spi_miso = spi_mosi;

  always #5 clk = ~clk;

  adrv9001_spi_master #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH),
    .CS_SETUP   (CS_SETUP),
    .CS_HOLD    (CS_HOLD),
    .CS_IDLE    (CS_IDLE)
  ) dut (
    .s_axi_aclk       (clk),
    .s_axi_areset     (rst),
    .mspi_axis_tdata  (m_tdata),
    .mspi_axis_tvalid (m_tvalid),
    .mspi_axis_enable (m_enable),
    .mspi_axis_tready (m_tready),
    .sspi_axis_tdata  (s_tdata),
    .sspi_axis_tvalid (s_tvalid),
    .sspi_axis_tready (s_tready),
    .spi_clk          (spi_clk),
    .spi_csn          (spi_csn),
    .spi_mosi         (spi_mosi),
    .spi_miso         (spi_miso),
    .busy             (busy),
    .tx_overflow      (tx_overflow),
    .rx_overflow      (rx_overflow)
  );

  int          checks = 0;
  int          errors = 0;
  bit          exp_bits[$];
  logic [7:0]  exp_rx[$];
  int unsigned rises = 0, windows = 0, low_cnt = 0, last_low = 0, cyc = 0;
  int unsigned t_csn_rise = 0, t_busy_fall = 0, t_fall = 0, rx_lat = 0;
  logic        prev_clk = 1'b0, prev_csn = 1'b1, prev_busy = 1'b0, prev_tvalid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Line-level model: each accepted byte contributes 8 bits MSB-first, and
  // every SCLK rise must present the next one on MOSI.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_bits.delete();
      prev_clk = 1'b0; prev_csn = 1'b1; prev_busy = 1'b0; prev_tvalid = 1'b0;
      low_cnt = 0;
    end else begin
      if (spi_clk && !prev_clk) begin
        rises++;
        if (exp_bits.size() == 0) check("mosi_queue_empty_at_rise", exp_bits.size(), 1);
        else check("mosi_bit", spi_mosi, exp_bits.pop_front());
      end
      if (!spi_clk && prev_clk) t_fall = cyc;
      if (!spi_csn) low_cnt++;
      else if (!prev_csn) begin
        last_low = low_cnt; low_cnt = 0; windows++; t_csn_rise = cyc;
      end
      if (!busy && prev_busy) t_busy_fall = cyc;
      if (s_tvalid && !prev_tvalid) rx_lat = cyc - t_fall;
      prev_clk = spi_clk; prev_csn = spi_csn; prev_busy = busy; prev_tvalid = s_tvalid;
    end
  end

  task automatic wr(input logic [7:0] d, input logic en, input bit exp_ok);
    bit ok;
    @(negedge clk);
    ok = m_tready;
    check("tx_accept", ok, exp_ok);
    m_tdata = d; m_enable = en; m_tvalid = 1'b1;
    if (exp_ok) for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
  endtask

  task automatic wr_end();
    @(negedge clk);
    m_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    check("idle_timeout", busy, 0);
    @(negedge clk);
  endtask

  task automatic pop(input logic [7:0] exp, input string name);
    int unsigned n = 0;
    @(negedge clk);
    while (!s_tvalid && n < 200) begin @(negedge clk); n++; end
    check({name, "_tvalid"}, s_tvalid, 1);
    check(name, s_tdata, exp);
    s_tready = 1'b1;
    @(negedge clk);
    s_tready = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  data;
    int unsigned csn_low;
    logic [7:0]  rx;
  } vec_t;

  vec_t        vecs[5];
  int unsigned base_r, base_w, n, nb;
  logic [7:0]  d;

  initial begin
    vecs[0] = '{8'hA5, 36, 8'hA5};
    vecs[1] = '{8'h00, 36, 8'h00};
    vecs[2] = '{8'hFF, 36, 8'hFF};
    vecs[3] = '{8'h3C, 36, 8'h3C};
    vecs[4] = '{8'h81, 36, 8'h81};

    // Reset values, both during and just after reset
    repeat (3) @(negedge clk);
    check("rst_csn", spi_csn, 1);
    check("rst_clk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_txovf", tx_overflow, 0);
    check("rst_rxovf", rx_overflow, 0);
    check("rst_tready", m_tready, 1);
    check("rst_tvalid", s_tvalid, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_csn", spi_csn, 1);
    check("post_rst_busy", busy, 0);

    // Single-byte transactions from the vector table
    foreach (vecs[k]) begin
      base_r = rises;
      wr(vecs[k].data, 1'b0, 1'b1);
      @(negedge clk); m_tvalid = 1'b0;
      check("csn_before_latency", spi_csn, 1);
      @(negedge clk);
      check("csn_fall_latency", spi_csn, 0);
      wait_idle(400);
      check("csn_low_cycles", last_low, vecs[k].csn_low);
      check("sclk_rises", rises - base_r, 8);
      check("busy_after_csn", t_busy_fall - t_csn_rise, CS_IDLE);
      check("rx_valid_latency", rx_lat, 1);
      pop(vecs[k].rx, "rx_byte");
      check("rx_empty_after_pop", s_tvalid, 0);
    end

    // Three-byte burst in one CSn window
    base_r = rises; base_w = windows;
    wr(8'h80, 1'b1, 1'b1);
    wr(8'h12, 1'b1, 1'b1);
    wr(8'h34, 1'b0, 1'b1);
    wr_end();
    wait_idle(1000);
    check("burst_windows", windows - base_w, 1);
    check("burst_rises", rises - base_r, 24);
    pop(8'h80, "burst_rx0");
    pop(8'h12, "burst_rx1");
    pop(8'h34, "burst_rx2");
    check("burst_rx_empty", s_tvalid, 0);

    // Slow feed: CSn must stay low through the gap with SCLK parked low
    base_r = rises; base_w = windows;
    wr(8'h55, 1'b1, 1'b1);
    wr_end();
    repeat (100) @(negedge clk);
    check("gap_csn", spi_csn, 0);
    check("gap_clk", spi_clk, 0);
    check("gap_busy", busy, 1);
    check("gap_no_window_end", windows - base_w, 0);
    wr(8'hAA, 1'b0, 1'b1);
    wr_end();
    wait_idle(1000);
    check("slow_windows", windows - base_w, 1);
    check("slow_rises", rises - base_r, 16);
    pop(8'h55, "slow_rx0");
    pop(8'hAA, "slow_rx1");

    // Randomised transactions with random inter-byte gaps
    for (int t = 0; t < 25; t++) begin
      base_r = rises; base_w = windows;
      nb = $urandom_range(1, 4);
      for (int j = 0; j < int'(nb); j++) begin
        d = 8'($urandom);
        wr(d, (j != int'(nb) - 1), 1'b1);
        exp_rx.push_back(d);
        if ($urandom_range(0, 3) == 0) begin
          wr_end();
          repeat ($urandom_range(1, 60)) @(negedge clk);
        end
      end
      wr_end();
      wait_idle(2000);
      check("rand_windows", windows - base_w, 1);
      check("rand_rises", rises - base_r, 8 * nb);
      while (exp_rx.size() != 0) pop(exp_rx.pop_front(), "rand_rx");
      check("rand_rx_empty", s_tvalid, 0);
    end

    // TX overflow: first byte is taken by the FSM, 16 more fill the FIFO
    wr(8'h01, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i), 1'b1, 1'b1);
    wr(8'hEE, 1'b1, 1'b0);
    wr_end();
    check("txovf_flag", tx_overflow, 1);
    check("txovf_tready", m_tready, 0);
    repeat (5) @(negedge clk);
    check("txovf_sticky", tx_overflow, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("txovf_cleared", tx_overflow, 0);
    check("txovf_tready_after_rst", m_tready, 1);
    check("txovf_csn_after_rst", spi_csn, 1);

    // RX overflow: 17 single-byte transactions with no pops
    for (int i = 0; i < 17; i++) begin
      wr(8'(i * 7 + 3), 1'b0, 1'b1);
      wr_end();
      wait_idle(400);
      if (i == 15) begin
        check("rxovf_not_yet", rx_overflow, 0);
        check("rxovf_valid", s_tvalid, 1);
      end
    end
    check("rxovf_flag", rx_overflow, 1);
    for (int i = 0; i < 16; i++) pop(8'(i * 7 + 3), "rxovf_rx");
    check("rxovf_drained", s_tvalid, 0);

    // Reset asserted during the third SCLK high phase
    base_r = rises;
    wr(8'hFF, 1'b0, 1'b1);
    wr(8'h11, 1'b0, 1'b1);
    wr_end();
    n = 0;
    while (rises - base_r < 3 && n < 200) begin @(negedge clk); n++; end
    check("midrst_third_rise", rises - base_r, 3);
    check("midrst_clk_high", spi_clk, 1);
    check("midrst_mosi_high", spi_mosi, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_csn", spi_csn, 1);
    check("midrst_clk", spi_clk, 0);
    check("midrst_mosi", spi_mosi, 0);
    check("midrst_tvalid", s_tvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rxovf", rx_overflow, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("midrst_tx_empty_csn", spi_csn, 1);
    check("midrst_no_rx", s_tvalid, 0);
    check("midrst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
